// File: rtl/note_tone_player_pkg.sv
// Shared definitions for the song-memory note interface.
// Imported by the note player and the song memory.
package note_tone_player_pkg;

  localparam int NOTE_W_DEF = 20;
  localparam int DUR_W      = 2;
  localparam int END_CODE   = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_PLAY = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

endpackage

// File: rtl/note_tone_player_tone_divider.sv
// Square-wave generator: toggles sq every half_period clocks
// while enabled; clr restarts the wave low with a fresh count.
module tone_divider #(
  parameter int NOTE_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [NOTE_W-1:0] half_period,
  output logic              sq
);

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              sq_q, sq_d;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (clr) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en) begin
      if (cnt_q == half_period - NOTE_W'(1)) begin
        cnt_d = '0;
        sq_d  = ~sq_q;
      end else begin
        cnt_d = cnt_q + NOTE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/note_tone_player.sv
// Song player: requests notes, latches half-period/duration,
// plays each note for its beats, then a silent gap.
module note_tone_player
  import note_tone_player_pkg::*;
#(
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int LATCH_DLY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  output logic              note_req,
  output logic              audio_out,
  output logic              playing,
  output logic              song_end
);

  localparam int BW      = $clog2(4 * BEAT_CYCLES);
  localparam int AUX_MAX = (GAP_CYCLES > LATCH_DLY) ?
                           GAP_CYCLES : LATCH_DLY;
  localparam int AW      = $clog2(AUX_MAX + 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]     aux_cnt_q, aux_cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              song_end_q, song_end_d;
  logic [BW-1:0]     beat_lim;
  logic              wait_done, gap_done, beat_done;
  logic              sq;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = '0;
    aux_cnt_d  = '0;
    note_d     = note_q;
    dur_d      = dur_q;
    song_end_d = 1'b0;
    beat_lim   = BW'((32'(dur_q) + 32'd1)
               * 32'(BEAT_CYCLES) - 32'd1);
    wait_done  = aux_cnt_q == AW'(LATCH_DLY - 1);
    gap_done   = aux_cnt_q == AW'(GAP_CYCLES - 1);
    beat_done  = beat_cnt_q == beat_lim;
    // stop beats start; both beat anything the FSM wanted
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_REQ;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_REQ:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (wait_done) begin
            note_d = note;
            dur_d  = duration;
            if (note == NOTE_W'(END_CODE)) begin
              song_end_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_PLAY;
            end
          end else begin
            aux_cnt_d = aux_cnt_q + AW'(1);
          end
        end
        ST_PLAY: begin
          if (beat_done) state_d = ST_GAP;
          else beat_cnt_d = beat_cnt_q + BW'(1);
        end
        ST_GAP: begin
          if (gap_done) state_d = ST_REQ;
          else aux_cnt_d = aux_cnt_q + AW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      aux_cnt_q  <= '0;
      note_q     <= '0;
      dur_q      <= '0;
      song_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      aux_cnt_q  <= aux_cnt_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      song_end_q <= song_end_d;
    end
  end

  tone_divider #(
    .NOTE_W(NOTE_W)
  ) u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state_q != ST_PLAY),
    .en         (state_q == ST_PLAY),
    .half_period(note_q),
    .sq         (sq)
  );

  assign note_req  = state_q == ST_REQ;
  assign playing   = state_q != ST_IDLE;
  assign song_end  = song_end_q;
  assign audio_out = sq & (state_q == ST_PLAY);

endmodule

// File: tb/tb_note_tone_player.sv
// Directed bench for note_tone_player with short beat/gap
// parameters: vector table plus multi-cycle note sequences.
module tb_note_tone_player;

  localparam int NW   = 20;
  localparam int BEAT = 100;
  localparam int GAP  = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [NW-1:0] note;
  logic [1:0]    duration;
  logic          note_req;
  logic          audio_out;
  logic          playing;
  logic          song_end;

  int n_run  = 0;
  int n_fail = 0;

  note_tone_player #(
    .NOTE_W     (NW),
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAP),
    .LATCH_DLY  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .note     (note),
    .duration (duration),
    .note_req (note_req),
    .audio_out(audio_out),
    .playing  (playing),
    .song_end (song_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic          sp;
    logic [NW-1:0] nt;
    logic [3:0]    exp;
    string         nm;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({note_req, audio_out, playing, song_end});
  endfunction

  // Entered while observing REQ; leaves while observing next REQ.
  task automatic run_note(input int nt, input int dur,
                          input int chg_k, input int chg_nt,
                          input int exp_tg, input string nm);
    int   werr = 0;
    int   gerr = 0;
    int   tg   = 0;
    logic prev = 1'b0;
    logic ea;
    note     = NW'(nt);
    duration = 2'(dur);
    tick();
    tick();
    tick();
    for (int k = 0; k < (dur + 1) * BEAT; k++) begin
      ea = ((k / nt) % 2) != 0;
      if (audio_out !== ea || playing !== 1'b1 ||
          note_req !== 1'b0) werr++;
      if (audio_out !== prev) tg++;
      prev = audio_out;
      if (k == chg_k) note = NW'(chg_nt);
      tick();
    end
    for (int g = 0; g < GAP; g++) begin
      if (audio_out !== 1'b0 || note_req !== 1'b0 ||
          playing !== 1'b1) gerr++;
      if (audio_out !== prev) tg++;
      prev = audio_out;
      tick();
    end
    check({nm, "_wave_err"}, werr, 0);
    check({nm, "_toggles"}, tg, exp_tg);
    check({nm, "_gap_err"}, gerr, 0);
    check({nm, "_next_req"}, int'(note_req), 1);
  endtask

  initial begin
    int   err;
    logic ea;
    vt[0]  = '{1'b1, 1'b0, 20'd0, 4'b1010, "idle_start"};
    vt[1]  = '{1'b0, 1'b0, 20'd0, 4'b0010, "wait0"};
    vt[2]  = '{1'b0, 1'b0, 20'd0, 4'b0010, "wait1"};
    vt[3]  = '{1'b0, 1'b0, 20'd0, 4'b0001, "end_pulse"};
    vt[4]  = '{1'b0, 1'b0, 20'd5, 4'b0000, "end_once"};
    vt[5]  = '{1'b1, 1'b1, 20'd5, 4'b0000, "start_stop"};
    vt[6]  = '{1'b1, 1'b0, 20'd5, 4'b1010, "start2"};
    vt[7]  = '{1'b0, 1'b1, 20'd5, 4'b0000, "stop_req"};
    vt[8]  = '{1'b1, 1'b0, 20'd5, 4'b1010, "start3"};
    vt[9]  = '{1'b0, 1'b0, 20'd5, 4'b0010, "w0"};
    vt[10] = '{1'b0, 1'b0, 20'd5, 4'b0010, "w1"};
    vt[11] = '{1'b1, 1'b0, 20'd5, 4'b1010, "latch_start"};
    vt[12] = '{1'b0, 1'b0, 20'd0, 4'b0010, "w0b"};
    vt[13] = '{1'b0, 1'b0, 20'd0, 4'b0010, "w1b"};
    vt[14] = '{1'b0, 1'b1, 20'd0, 4'b0000, "latch_stop"};
    vt[15] = '{1'b0, 1'b0, 20'd0, 4'b0000, "idle_after"};

    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    note     = '0;
    duration = '0;
    #12;
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      start = vt[i].st;
      stop  = vt[i].sp;
      note  = vt[i].nt;
      tick();
      check(vt[i].nm, outs(), int'(vt[i].exp));
    end
    start = 1'b0;
    stop  = 1'b0;

    // asynchronous reset in the middle of a note
    note     = 20'd5;
    duration = 2'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_reset_audio", int'(audio_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 0);
    #20;
    rst_n = 1'b1;
    err = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (outs() != 0) err++;
    end
    check("post_reset_idle", err, 0);

    // one-beat note followed by a four-beat note
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req_after_start", outs(), 4'b1010);
    run_note(5, 0, -1, 0, 20, "n5d0");
    run_note(5, 3, 50, 9, 80, "n5d3");

    // stop at PLAY cycle 37
    note     = 20'd5;
    duration = 2'd0;
    tick();
    tick();
    tick();
    for (int k = 0; k < 37; k++) tick();
    check("pre_stop_audio", int'(audio_out), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_play", outs(), 0);
    tick();
    check("stay_idle", outs(), 0);

    // restart from GAP
    note  = 20'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < BEAT + 3; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req_from_gap", outs(), 4'b1010);
    note = 20'd7;
    tick();
    tick();
    tick();
    err = 0;
    for (int k = 0; k < 14; k++) begin
      ea = ((k / 7) % 2) != 0;
      if (audio_out !== ea) err++;
      tick();
    end
    check("fresh_tone_err", err, 0);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
